sif_xa_target: RTL and testbench

//  Synthesisable SIF responder that terminates the XA side and forwards data on the WA side.
//  - Counterpart of the testbench driver, which issues the WRITE/READ/IDLE/ILLEGAL/RESET operations.
//  - XA writes are queued in a FIFO and streamed out on WA with a valid/ready handshake.
//  - XA reads return the last accepted write value.
//  - The XA and WA monitors and the reference model check this block.

---
 rtl/sif_xa_target.sv | 162 ++++++++++++++++
 tb/tb_sif_xa_target.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sif_xa_target.sv
// SIF XA responder: queues XA writes in a FIFO, streams them on WA.
// Optional odd-parity check on XA writes: define SIF_XA_PARITY_EN.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   xa_wr_s, xa_rd_s         XA write / read strobes
//   xa_data_wr               XA write data
//   xa_ready                 FIFO not full
//   xa_data_rd, xa_rd_vld    XA read response (one-cycle pulse)
//   err_illegal              pulse: both strobes high
//   wa_valid, wa_data        WA output beat
//   wa_ready                 WA sink ready
//   xa_par, err_parity       parity in / error pulse (SIF_XA_PARITY_EN)
module sif_xa_target #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH = 4,
  parameter logic [DATA_W-1:0] RD_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xa_wr_s,
  input  logic              xa_rd_s,
  input  logic [DATA_W-1:0] xa_data_wr,
  output logic              xa_ready,
  output logic [DATA_W-1:0] xa_data_rd,
  output logic              xa_rd_vld,
  output logic              err_illegal,
  output logic              wa_valid,
  output logic [DATA_W-1:0] wa_data,
  input  logic              wa_ready
`ifdef SIF_XA_PARITY_EN
  ,
  input  logic              xa_par,
  output logic              err_parity
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    WA_IDLE,
    WA_BUSY
  } wa_state_e;

  wa_state_e wa_state_q, wa_state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] wa_data_q, wa_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic              illegal_q, illegal_d;

  logic is_wr;
  logic is_rd;
  logic par_ok;
  logic push;
  logic pop;
  logic fifo_empty;

  assign is_wr = xa_wr_s & ~xa_rd_s;
  assign is_rd = xa_rd_s & ~xa_wr_s;

`ifdef SIF_XA_PARITY_EN
  logic par_err_q, par_err_d;

  // Odd parity: data bits plus xa_par must hold an odd number of ones.
  assign par_ok = ^{xa_data_wr, xa_par};
  assign par_err_d = is_wr & ~par_ok;
  assign err_parity = par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  // Full blocks pushes even when a pop happens in the same cycle.
  assign xa_ready   = (count_q != CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = is_wr & xa_ready & par_ok;

  always_comb begin
    wa_state_d = wa_state_q;
    pop        = 1'b0;
    unique case (wa_state_q)
      WA_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          wa_state_d = WA_BUSY;
        end
      end
      WA_BUSY: begin
        if (wa_ready) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            wa_state_d = WA_IDLE;
          end
        end
      end
      default: wa_state_d = WA_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    shadow_d  = push ? xa_data_wr : shadow_q;
    wa_data_d = pop ? mem_q[rd_ptr_q] : wa_data_q;
    rd_vld_d  = is_rd;
    rd_data_d = is_rd ? shadow_q : rd_data_q;
    illegal_d = xa_wr_s & xa_rd_s;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= xa_data_wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_state_q <= WA_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shadow_q   <= RD_RST_VAL;
      wa_data_q  <= '0;
      rd_data_q  <= '0;
      rd_vld_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      wa_state_q <= wa_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shadow_q   <= shadow_d;
      wa_data_q  <= wa_data_d;
      rd_data_q  <= rd_data_d;
      rd_vld_q   <= rd_vld_d;
      illegal_q  <= illegal_d;
    end
  end

  assign wa_valid    = (wa_state_q == WA_BUSY);
  assign wa_data     = wa_data_q;
  assign xa_data_rd  = rd_data_q;
  assign xa_rd_vld   = rd_vld_q;
  assign err_illegal = illegal_q;

endmodule

// File: tb/tb_sif_xa_target.sv
// Directed bench for sif_xa_target with a WA scoreboard queue.
// Inputs change 1 ns after rising edges; WA beats sampled on falling edges.
module tb_sif_xa_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        xa_wr_s;
  logic        xa_rd_s;
  logic [15:0] xa_data_wr;
  logic        xa_ready;
  logic [15:0] xa_data_rd;
  logic        xa_rd_vld;
  logic        err_illegal;
  logic        wa_valid;
  logic [15:0] wa_data;
  logic        wa_ready;
`ifdef SIF_XA_PARITY_EN
  logic        xa_par;
  logic        err_parity;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  sif_xa_target dut (
    .clk        (clk),
    .rst        (rst),
    .xa_wr_s    (xa_wr_s),
    .xa_rd_s    (xa_rd_s),
    .xa_data_wr (xa_data_wr),
    .xa_ready   (xa_ready),
    .xa_data_rd (xa_data_rd),
    .xa_rd_vld  (xa_rd_vld),
    .err_illegal(err_illegal),
    .wa_valid   (wa_valid),
    .wa_data    (wa_data),
    .wa_ready   (wa_ready)
`ifdef SIF_XA_PARITY_EN
    ,
    .xa_par     (xa_par),
    .err_parity (err_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completed WA beat must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && wa_valid && wa_ready) begin
      chk("wa_beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wa_data", 32'(wa_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d, input bit expect_accept);
    xa_wr_s = 1'b1;
    xa_rd_s = 1'b0;
    xa_data_wr = d;
`ifdef SIF_XA_PARITY_EN
    xa_par = ~^d;
`endif
    if (expect_accept) exp_q.push_back(d);
    step();
    xa_wr_s = 1'b0;
  endtask

  task automatic rd_chk(input logic [15:0] exp);
    xa_rd_s = 1'b1;
    step();
    xa_rd_s = 1'b0;
    chk("rd_vld_pulse", 32'(xa_rd_vld), 32'd1);
    chk("rd_data", 32'(xa_data_rd), 32'(exp));
    step();
    chk("rd_vld_end", 32'(xa_rd_vld), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    xa_wr_s = 1'b0;
    xa_rd_s = 1'b0;
    xa_data_wr = '0;
    wa_ready = 1'b1;
`ifdef SIF_XA_PARITY_EN
    xa_par = 1'b0;
`endif
    step();
    step();
    chk("rst_wa_valid", 32'(wa_valid), 32'd0);
    chk("rst_wa_data", 32'(wa_data), 32'd0);
    chk("rst_rd_vld", 32'(xa_rd_vld), 32'd0);
    chk("rst_rd_data", 32'(xa_data_rd), 32'd0);
    chk("rst_illegal", 32'(err_illegal), 32'd0);
    chk("rst_xa_ready", 32'(xa_ready), 32'd1);
    rst = 1'b0;

    // Basic write, two-cycle latency to WA, read-back.
    wr(16'hA5A5, 1'b1);
    chk("t1_valid_n", 32'(wa_valid), 32'd0);
    step();
    chk("t1_valid_n1", 32'(wa_valid), 32'd1);
    chk("t1_data_n1", 32'(wa_data), 32'h0000A5A5);
    step();
    rd_chk(16'hA5A5);

    // Stalled sink: fill output reg + FIFO, sixth write dropped.
    wa_ready = 1'b0;
    for (int i = 1; i <= 6; i++) wr(16'(i), i <= 5);
    chk("t2_xa_ready_full", 32'(xa_ready), 32'd0);
    chk("t2_valid", 32'(wa_valid), 32'd1);
    chk("t2_head", 32'(wa_data), 32'd1);
    wa_ready = 1'b1;
    drain();
    chk("t2_xa_ready_after", 32'(xa_ready), 32'd1);
    rd_chk(16'h0005);

    // Illegal op: error pulse, no beat, shadow untouched.
    xa_wr_s = 1'b1;
    xa_rd_s = 1'b1;
    xa_data_wr = 16'hFFFF;
    step();
    xa_wr_s = 1'b0;
    xa_rd_s = 1'b0;
    chk("t3_illegal", 32'(err_illegal), 32'd1);
    chk("t3_no_rd", 32'(xa_rd_vld), 32'd0);
    step();
    chk("t3_illegal_end", 32'(err_illegal), 32'd0);
    chk("t3_no_beat", 32'(wa_valid), 32'd0);
    rd_chk(16'h0005);

    // Reset mid-stream discards everything immediately.
    wa_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'h0010 + 16'(i), 1'b0);
    chk("t4_valid_pre", 32'(wa_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(wa_valid), 32'd0);
    chk("t4_rst_data", 32'(wa_data), 32'd0);
    chk("t4_rst_ready", 32'(xa_ready), 32'd1);
    step();
    rst = 1'b0;
    wa_ready = 1'b1;
    step();
    step();
    chk("t4_no_beat", 32'(wa_valid), 32'd0);
    rd_chk(16'h0000);

    // Streaming at full rate through pointer wrap.
    for (int i = 0; i < 32; i++) begin
      wr(16'h0100 + 16'(i), 1'b1);
      xa_wr_s = 1'b0;
      chk("t5_xa_ready", 32'(xa_ready), 32'd1);
      if (i >= 1) chk("t5_valid", 32'(wa_valid), 32'd1);
      if (i >= 1) chk("t5_data", 32'(wa_data), 32'h0100 + 32'(i) - 32'd1);
      xa_wr_s = (i < 31);
    end
    xa_wr_s = 1'b0;
    drain();

`ifdef SIF_XA_PARITY_EN
    // Bad parity write rejected; good one streams out.
    step();
    xa_wr_s = 1'b1;
    xa_data_wr = 16'h0001;
    xa_par = 1'b1;
    step();
    xa_wr_s = 1'b0;
    chk("t6_err_parity", 32'(err_parity), 32'd1);
    step();
    chk("t6_err_end", 32'(err_parity), 32'd0);
    chk("t6_no_beat", 32'(wa_valid), 32'd0);
    rd_chk(16'h011F);
    wr(16'h0001, 1'b1);
    chk("t6_good_no_err", 32'(err_parity), 32'd0);
    drain();
`endif

    step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
